// File: rtl/config_chain_loader.sv
// Configuration-chain loader: streams a CHAIN_LEN-bit configuration in/out SCAN_WIDTH bits
// per beat through a shadow register, committing to the active configuration atomically.
module config_chain_loader #(
  parameter int CHAIN_LEN  = 64,
  parameter int SCAN_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic                  abort_i,
  input  logic                  bs_valid_i,
  input  logic [SCAN_WIDTH-1:0] bs_data_i,
  output logic                  bs_ready_o,
  output logic                  rb_valid_o,
  output logic [SCAN_WIDTH-1:0] rb_data_o,
  input  logic                  rb_ready_i,
  output logic [CHAIN_LEN-1:0]  cfg_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BEATS = CHAIN_LEN / SCAN_WIDTH;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_IN  = 2'd1,
    COMMIT    = 2'd2,
    SHIFT_OUT = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CHAIN_LEN-1:0] cfg_q, cfg_d;
  logic                 done_q, done_d;
  logic                 bs_ready_q, rb_valid_q, busy_q;
  logic [CHAIN_LEN-1:0] shift_in_s, shift_out_s;

  // Shifting by the full width yields zero, so BEATS==1 needs no special case.
  assign shift_in_s  = (shadow_q << SCAN_WIDTH) | CHAIN_LEN'(bs_data_i);
  assign shift_out_s = shadow_q << SCAN_WIDTH;

  // Next-state and datapath update; abort overrides any beat accepted in the same cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    done_d   = done_q;
    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cnt_d  = '0;
            done_d = 1'b0;
            if (mode_i) begin
              shadow_d = cfg_q;
              state_d  = SHIFT_OUT;
            end else begin
              state_d = SHIFT_IN;
            end
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT_IN: begin
          if (bs_valid_i) begin
            shadow_d = shift_in_s;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              state_d = COMMIT;
            end else begin
              state_d = SHIFT_IN;
            end
          end else begin
            state_d = SHIFT_IN;
          end
        end
        COMMIT: begin
          cfg_d   = shadow_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        SHIFT_OUT: begin
          if (rb_ready_i) begin
            shadow_d = shift_out_s;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = SHIFT_OUT;
            end
          end else begin
            state_d = SHIFT_OUT;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, datapath and registered handshake decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shadow_q   <= '0;
      cfg_q      <= '0;
      done_q     <= 1'b0;
      bs_ready_q <= 1'b0;
      rb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      cfg_q      <= cfg_d;
      done_q     <= done_d;
      bs_ready_q <= (state_d == SHIFT_IN);
      rb_valid_q <= (state_d == SHIFT_OUT);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bs_ready_o = bs_ready_q;
  assign rb_valid_o = rb_valid_q;
  assign rb_data_o  = shadow_q[CHAIN_LEN-1 -: SCAN_WIDTH];
  assign cfg_o      = cfg_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: a 16/4 instance and an 8/8 instance, directed plus random
// transfers checked against a value-level model of the loaded configuration.
module tb_config_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic a_start, a_mode, a_abort, a_bs_valid, a_rb_ready;
  logic [3:0] a_bs_data, a_rb_data;
  logic a_bs_ready, a_rb_valid, a_busy, a_done;
  logic [15:0] a_cfg;

  logic b_start, b_mode, b_abort, b_bs_valid, b_rb_ready;
  logic [7:0] b_bs_data, b_rb_data;
  logic b_bs_ready, b_rb_valid, b_busy, b_done;
  logic [7:0] b_cfg;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] m_cfg;
  logic [7:0]  mb_cfg;

  config_chain_loader #(.CHAIN_LEN(16), .SCAN_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .start_i(a_start), .mode_i(a_mode), .abort_i(a_abort),
    .bs_valid_i(a_bs_valid), .bs_data_i(a_bs_data), .bs_ready_o(a_bs_ready),
    .rb_valid_o(a_rb_valid), .rb_data_o(a_rb_data), .rb_ready_i(a_rb_ready),
    .cfg_o(a_cfg), .busy_o(a_busy), .done_o(a_done));

  config_chain_loader #(.CHAIN_LEN(8), .SCAN_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .start_i(b_start), .mode_i(b_mode), .abort_i(b_abort),
    .bs_valid_i(b_bs_valid), .bs_data_i(b_bs_data), .bs_ready_o(b_bs_ready),
    .rb_valid_o(b_rb_valid), .rb_data_o(b_rb_data), .rb_ready_i(b_rb_ready),
    .cfg_o(b_cfg), .busy_o(b_busy), .done_o(b_done));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load val MSB-nibble first with random valid gaps; optionally re-pulse start mid-load.
  task automatic a_load(input logic [15:0] val, input int max_stall, input bit poke_start);
    int ns;
    a_start = 1'b1; a_mode = 1'b0;
    tick();
    a_start = 1'b0;
    chk("ld_busy", 64'(a_busy), 64'(1'b1));
    chk("ld_bs_ready", 64'(a_bs_ready), 64'(1'b1));
    chk("ld_done_clr", 64'(a_done), 64'(1'b0));
    for (int i = 0; i < 4; i++) begin
      ns = $urandom_range(0, max_stall);
      for (int s = 0; s < ns; s++) begin
        a_bs_valid = 1'b0; a_bs_data = 4'($urandom);
        tick();
        chk("ld_stall_ready", 64'(a_bs_ready), 64'(1'b1));
        chk("ld_stall_cfg", 64'(a_cfg), 64'(m_cfg));
      end
      a_bs_valid = 1'b1;
      a_bs_data  = val[15-4*i -: 4];
      a_start    = poke_start && (i == 1);
      tick();
      a_bs_valid = 1'b0; a_start = 1'b0;
      chk("ld_cfg_hold", 64'(a_cfg), 64'(m_cfg));
    end
    chk("commit_ready", 64'(a_bs_ready), 64'(1'b0));
    chk("commit_busy", 64'(a_busy), 64'(1'b1));
    tick();
    m_cfg = val;
    chk("ld_cfg", 64'(a_cfg), 64'(m_cfg));
    chk("ld_done", 64'(a_done), 64'(1'b1));
    chk("ld_idle", 64'(a_busy), 64'(1'b0));
  endtask

  // Read back with random ready gaps; beats must match the model MSB first.
  task automatic a_readback(input int max_stall);
    int ns;
    a_start = 1'b1; a_mode = 1'b1;
    tick();
    a_start = 1'b0; a_mode = 1'b0;
    chk("rb_busy", 64'(a_busy), 64'(1'b1));
    chk("rb_done_clr", 64'(a_done), 64'(1'b0));
    for (int i = 0; i < 4; i++) begin
      ns = $urandom_range(0, max_stall);
      for (int s = 0; s < ns; s++) begin
        a_rb_ready = 1'b0;
        chk("rb_valid", 64'(a_rb_valid), 64'(1'b1));
        chk("rb_data_stall", 64'(a_rb_data), 64'(m_cfg[15-4*i -: 4]));
        tick();
      end
      chk("rb_valid", 64'(a_rb_valid), 64'(1'b1));
      chk("rb_data", 64'(a_rb_data), 64'(m_cfg[15-4*i -: 4]));
      a_rb_ready = 1'b1;
      tick();
      a_rb_ready = 1'b0;
    end
    chk("rb_end_valid", 64'(a_rb_valid), 64'(1'b0));
    chk("rb_end_busy", 64'(a_busy), 64'(1'b0));
    chk("rb_end_done", 64'(a_done), 64'(1'b1));
    chk("rb_cfg_keep", 64'(a_cfg), 64'(m_cfg));
  endtask

  task automatic b_load(input logic [7:0] val);
    b_start = 1'b1; b_mode = 1'b0;
    tick();
    b_start = 1'b0;
    chk("b_ready", 64'(b_bs_ready), 64'(1'b1));
    b_bs_valid = 1'b1; b_bs_data = val;
    tick();
    b_bs_valid = 1'b0;
    chk("b_commit_cfg_old", 64'(b_cfg), 64'(mb_cfg));
    chk("b_commit_busy", 64'(b_busy), 64'(1'b1));
    tick();
    mb_cfg = val;
    chk("b_cfg", 64'(b_cfg), 64'(mb_cfg));
    chk("b_done", 64'(b_done), 64'(1'b1));
    chk("b_idle", 64'(b_busy), 64'(1'b0));
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_mode = 1'b0; a_abort = 1'b0; a_bs_valid = 1'b0; a_rb_ready = 1'b0;
    a_bs_data = 4'h0;
    b_start = 1'b0; b_mode = 1'b0; b_abort = 1'b0; b_bs_valid = 1'b0; b_rb_ready = 1'b0;
    b_bs_data = 8'h00;
    m_cfg = 16'h0000; mb_cfg = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_cfg", 64'(a_cfg), 64'(16'h0000));
    chk("rst_busy", 64'(a_busy), 64'(1'b0));
    chk("rst_done", 64'(a_done), 64'(1'b0));
    chk("rst_bs_ready", 64'(a_bs_ready), 64'(1'b0));
    chk("rst_rb_valid", 64'(a_rb_valid), 64'(1'b0));
    chk("rst_rb_data", 64'(a_rb_data), 64'(4'h0));

    // Plain load, stalled load, then readback with ready gaps.
    a_load(16'hABCD, 0, 1'b0);
    a_load(16'hABCD, 1, 1'b0);
    a_readback(2);

    // Abort mid-load; an accepted beat in the abort cycle is discarded.
    a_load(16'h1234, 0, 1'b0);
    a_start = 1'b1; a_mode = 1'b0;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_bs_valid = 1'b1; a_bs_data = 4'hF;
      tick();
    end
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0; a_bs_valid = 1'b0;
    chk("abort_busy", 64'(a_busy), 64'(1'b0));
    chk("abort_ready", 64'(a_bs_ready), 64'(1'b0));
    chk("abort_done", 64'(a_done), 64'(1'b0));
    chk("abort_cfg", 64'(a_cfg), 64'(m_cfg));
    a_load(16'h5678, 0, 1'b0);

    // Start re-pulsed during the load must be ignored.
    a_load(16'h9E3C, 1, 1'b1);

    // Random loads and readbacks.
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 0) a_load(16'($urandom), 2, 1'b0);
      else a_readback(2);
    end

    // 8/8 instance: single-beat load and readback.
    b_load(8'h5A);
    b_start = 1'b1; b_mode = 1'b1;
    tick();
    b_start = 1'b0; b_mode = 1'b0;
    chk("b_rb_valid", 64'(b_rb_valid), 64'(1'b1));
    chk("b_rb_data", 64'(b_rb_data), 64'(mb_cfg));
    b_rb_ready = 1'b1;
    tick();
    b_rb_ready = 1'b0;
    chk("b_rb_end", 64'(b_rb_valid), 64'(1'b0));
    chk("b_rb_done", 64'(b_done), 64'(1'b1));
    b_load(8'($urandom));

    // Asynchronous reset after the third beat: everything clears, no commit.
    a_start = 1'b1; a_mode = 1'b0;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_bs_valid = 1'b1; a_bs_data = 4'($urandom);
      tick();
    end
    a_bs_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    m_cfg = 16'h0000;
    chk("arst_cfg", 64'(a_cfg), 64'(m_cfg));
    chk("arst_busy", 64'(a_busy), 64'(1'b0));
    chk("arst_done", 64'(a_done), 64'(1'b0));
    chk("arst_ready", 64'(a_bs_ready), 64'(1'b0));
    chk("arst_rb_data", 64'(a_rb_data), 64'(4'h0));
    chk("arst_b_cfg", 64'(b_cfg), 64'(8'h00));
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 64'(a_busy), 64'(1'b0));
    chk("post_rst_cfg", 64'(a_cfg), 64'(m_cfg));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Parametrised configuration-chain loader for the FPGA fabric: it generalises the single-bit scannable register into a CHAIN_LEN-bit configuration register that is loaded and read back SCAN_WIDTH bits per beat over a valid/ready stream. A shadow shift register absorbs the bitstream, so the active configuration `cfg_q` never changes during shifting. `cfg_q` is committed atomically only after a complete load. The block sits between the bitstream port and the configuration inputs of the logic blocks and routing muxes.

## Interface
- CHAIN_LEN, 64, total configuration bits; must be a multiple of SCAN_WIDTH.
- SCAN_WIDTH, 4, bits transferred per beat; must be ≥1.
- BEATS (localparam), CHAIN_LEN/SCAN_WIDTH, beats per full transfer.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  sampled with start: 0 selects load, 1 selects readback.
- abort  in  1  returns the block to IDLE from any state; `cfg_q` is unchanged.
- bs_valid  in  1  load data valid.
- bs_data  in  SCAN_WIDTH  load data beat.
- bs_ready  out  1  high only in state SHIFT_IN.
- rb_valid  out  1  high only in state SHIFT_OUT.
- rb_data  out  SCAN_WIDTH  readback beat; equals `shadow[CHAIN_LEN-1 -: SCAN_WIDTH]`.
- rb_ready  in  1  readback consumer ready.
- cfg_q  out  CHAIN_LEN  active configuration.
- busy  out  1  high when the state is not IDLE.
- done  out  1  sticky flag set on commit; cleared by an accepted start or by abort.

## Operation
- States: IDLE, SHIFT_IN, COMMIT, SHIFT_OUT. `beat_cnt` has width clog2(BEATS+1).
- IDLE:
  - start & !mode → SHIFT_IN, beat_cnt←0, done←0.
  - start & mode → SHIFT_OUT, shadow←cfg_q, beat_cnt←0, done←0.
- SHIFT_IN:
  - A beat is accepted when bs_valid & bs_ready.
  - On acceptance: shadow←{shadow[CHAIN_LEN-SCAN_WIDTH-1:0], bs_data}, beat_cnt+1.
  - When the accepted beat is number BEATS → COMMIT.
  - The first beat ends up at the MSB end of the chain.
- COMMIT: one cycle. cfg_q←shadow, done←1, then → IDLE. bs_ready=0 in this state.
- SHIFT_OUT:
  - A beat is accepted when rb_valid & rb_ready.
  - On acceptance: shadow shifts left by SCAN_WIDTH (zero fill), beat_cnt+1.
  - When beat BEATS is accepted → IDLE; done←1, cfg_q unchanged.
  - Beats come out MSB first, i.e. in the same order as they were loaded.
- Priority:
  - abort > rst-free normal operation. abort in any state → IDLE next edge, done←0, shadow contents don't-care.
  - abort in the same cycle as an accepted beat: the beat is discarded.
- start while busy is ignored; no queueing.
- Idle stalls (bs_valid=0 or rb_ready=0) hold state and counter indefinitely.
- SCAN_WIDTH==CHAIN_LEN is legal: BEATS=1, a single beat loads the whole chain.

## Timing
- Reset values: cfg_q=0, shadow=0, state=IDLE, beat_cnt=0, busy=0, done=0, bs_ready=0, rb_valid=0, rb_data=0.
- rst asserted mid-transfer clears everything immediately; no partial commit.
- Load latency: start sampled at edge 0. With no stalls, beats are accepted at edges 1..BEATS. cfg_q and done update at edge BEATS+1; busy falls at the same edge.
- Readback: rb_valid is high from edge 1 through the edge that accepts beat BEATS. rb_data is valid combinationally from shadow whenever rb_valid=1.
- bs_ready and rb_valid are registered state decodes; they do not depend combinationally on bs_valid or rb_ready.
- cfg_q changes on exactly one edge per completed load; it is never partially updated.

## Test plan
- CHAIN_LEN=16, SCAN_WIDTH=4, load beats A,B,C,D with no stalls → cfg_q=16'hABCD at edge 5 after start, done=1, busy=0 at edge 5, cfg_q=0 before that.
- Same load with bs_valid low on alternate cycles → cfg_q=16'hABCD only after the 4th accepted beat plus one cycle; cfg_q=0 throughout shifting.
- Readback after the load, with rb_ready toggling → rb_data sequence A,B,C,D with no repeats or drops; cfg_q stays 16'hABCD; done=1 at the end.
- Load 16'h1234, then start a new load, send 2 beats (F,F) and assert abort → IDLE next edge, cfg_q=16'h1234, done=0; a subsequent full load of 5,6,7,8 gives 16'h5678.
- start pulsed again during SHIFT_IN → ignored: beat_cnt is not reset and the load completes normally. rst asserted after beat 3 → all outputs 0 asynchronously and no commit occurs.
- CHAIN_LEN=8, SCAN_WIDTH=8 → a single beat 8'h5A gives cfg_q=8'h5A at edge 2 after start.
